// File: rtl/switch_event_pulser.sv
// switch_event_pulser
//   Multi-channel switch conditioner. Each channel passes its raw switch through a
//   2-flop synchroniser, debounces the synchronised value over DEBOUNCE_CYCLES
//   clocks, and emits single-cycle rise/fall pulses alongside a clean level.
//
// Ports
//   clk        in   1     rising-edge clock
//   rst        in   1     asynchronous active-low reset
//   switch_in  in   N_CH  raw asynchronous switch inputs
//   ch_en      in   N_CH  per-channel enable (0 = frozen, counter cleared, no events)
//   level      out  N_CH  debounced level (registered)
//   rise_pulse out  N_CH  one-cycle pulse on accepted 0->1
//   fall_pulse out  N_CH  one-cycle pulse on accepted 1->0
//   any_event  out  1     OR of all rise/fall pulse bits (combinational)
module switch_event_pulser #(
  parameter int   N_CH            = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] switch_in,
  input  logic [N_CH-1:0] ch_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic            any_event
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Terminal count: the edge on which cnt already holds D-1 is the D-th
  // consecutive disagreeing edge, so the new value is accepted there.
  localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;
  logic [N_CH-1:0] r_level;
  logic [N_CH-1:0] r_rise;
  logic [N_CH-1:0] r_fall;
  logic [CW-1:0]   r_cnt [N_CH];

  // Synchroniser runs regardless of ch_en so a re-enabled channel sees a settled value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= {N_CH{RESET_LEVEL}};
      r_sync2 <= {N_CH{RESET_LEVEL}};
    end else begin
      r_sync1 <= switch_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level <= {N_CH{RESET_LEVEL}};
      r_rise  <= '0;
      r_fall  <= '0;
      for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        // Pulses default low so each event is exactly one cycle wide.
        r_rise[i] <= 1'b0;
        r_fall[i] <= 1'b0;
        if (!ch_en[i]) begin
          r_cnt[i] <= '0;
        end else if (r_sync2[i] == r_level[i]) begin
          // Agreement (including a glitch returning) discards any partial count.
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LAST_CNT) begin
          r_level[i] <= r_sync2[i];
          r_rise[i]  <= r_sync2[i];
          r_fall[i]  <= ~r_sync2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign level      = r_level;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign any_event  = |(r_rise | r_fall);

endmodule

// File: tb/tb_switch_event_pulser.sv
// Testbench for switch_event_pulser (N_CH=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0).
// Reference model: a value is accepted once the synchronised input has disagreed
// with the accepted level, with the channel enabled, on each of the last D edges.
module tb_switch_event_pulser;

  localparam int   N  = 2;
  localparam int   D  = 4;
  localparam logic RL = 1'b0;

  logic         clk;
  logic         rst;
  logic [N-1:0] switch_in;
  logic [N-1:0] ch_en;
  logic [N-1:0] level;
  logic [N-1:0] rise_pulse;
  logic [N-1:0] fall_pulse;
  logic         any_event;

  int n_checks = 0;
  int n_fail   = 0;

  switch_event_pulser #(.N_CH(N), .DEBOUNCE_CYCLES(D), .RESET_LEVEL(RL)) dut (
    .clk        (clk),
    .rst        (rst),
    .switch_in  (switch_in),
    .ch_en      (ch_en),
    .level      (level),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .any_event  (any_event)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [N-1:0] m_s1, m_s2;
  logic [N-1:0] exp_level, exp_rise, exp_fall;
  logic [N-1:0] s_hist[$];
  logic [N-1:0] en_hist[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_s1      = {N{RL}};
      m_s2      = {N{RL}};
      exp_level = {N{RL}};
      exp_rise  = '0;
      exp_fall  = '0;
      s_hist.delete();
      en_hist.delete();
    end else begin
      s_hist.push_back(m_s2);
      en_hist.push_back(ch_en);
      if (s_hist.size() > D) begin
        void'(s_hist.pop_front());
        void'(en_hist.pop_front());
      end
      exp_rise = '0;
      exp_fall = '0;
      for (int c = 0; c < N; c++) begin
        bit fire;
        fire = (s_hist.size() == D);
        for (int k = 0; k < s_hist.size(); k++)
          if (!en_hist[k][c] || (s_hist[k][c] == exp_level[c])) fire = 0;
        if (fire) begin
          exp_level[c] = m_s2[c];
          exp_rise[c]  = m_s2[c];
          exp_fall[c]  = ~m_s2[c];
        end
      end
      m_s2 = m_s1;
      m_s1 = switch_in;
    end
  end

  // Compare on the falling edge, between active edges.
  always @(negedge clk) begin
    check("level",      32'(level),      32'(exp_level));
    check("rise_pulse", 32'(rise_pulse), 32'(exp_rise));
    check("fall_pulse", 32'(fall_pulse), 32'(exp_fall));
    check("any_event",  32'(any_event),  32'(|(exp_rise | exp_fall)));
  end

  // ---------------- driver helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b0;
    switch_in = '0;
    ch_en     = 2'b11;

    // 1: inputs toggling under reset produce nothing
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      switch_in = 2'($urandom_range(0, 3));
      check("rst_level", 32'(level), 32'h0);
      check("rst_evt",   32'(any_event), 32'h0);
    end
    @(negedge clk);
    switch_in = 2'b00;
    rst       = 1'b1;
    idle(4);

    // 2: clean rise on ch0, event after edge 5
    switch_in = 2'b01;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("t2_rise",  32'(rise_pulse), (k == 5) ? 32'h1 : 32'h0);
      check("t2_level", 32'(level),      (k >= 5) ? 32'h1 : 32'h0);
      check("t2_fall",  32'(fall_pulse), 32'h0);
    end

    // 3: glitch of 3 cycles rejected, then 6-cycle hold accepted
    @(negedge clk); switch_in = 2'b11;
    idle(3);        switch_in = 2'b01;
    idle(8);
    check("t3_glitch_level", 32'(level), 32'h1);
    switch_in = 2'b11;
    idle(6);
    switch_in = 2'b11;
    idle(4);
    check("t3_level", 32'(level), 32'h3);

    // 4: simultaneous events
    switch_in = 2'b00;
    idle(8);
    check("t4_level0", 32'(level), 32'h0);
    switch_in = 2'b11;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("t4_rise", 32'(rise_pulse), (k == 5) ? 32'h3 : 32'h0);
      check("t4_any",  32'(any_event),  (k == 5) ? 32'h1 : 32'h0);
    end
    @(negedge clk); switch_in = 2'b00;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("t4_fall", 32'(fall_pulse), (k == 5) ? 32'h3 : 32'h0);
    end
    check("t4_level1", 32'(level), 32'h0);

    // 1b: reset asserted mid-pulse clears the pulse without a clock edge
    @(negedge clk); switch_in = 2'b01;
    begin : wait_pulse
      bit seen;
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(posedge clk); #1;
        if (rise_pulse != 0) seen = 1;
      end
      check("t1_pulse_seen", 32'(seen), 32'h1);
    end
    #2 rst = 1'b0;
    #1;
    check("t1_async_rise",  32'(rise_pulse), 32'h0);
    check("t1_async_level", 32'(level),      32'h0);

    // 6: release with switches high -> one event at edge 5 after release
    switch_in = 2'b11;
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("t6_rise", 32'(rise_pulse), (k == 5) ? 32'h3 : 32'h0);
    end

    // 5: disabled channel frozen, then qualifies after re-enable
    @(negedge clk); switch_in = 2'b00;
    idle(8);
    ch_en     = 2'b10;
    switch_in = 2'b01;
    idle(20);
    check("t5_frozen_level", 32'(level), 32'h0);
    ch_en = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("t5_rise", 32'(rise_pulse), (k == 3) ? 32'h1 : 32'h0);
    end

    // mixed held patterns, including enable drops mid-count (model-checked)
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      switch_in = 2'($urandom_range(0, 3));
      ch_en     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      idle($urandom_range(0, 6));
    end
    ch_en = 2'b11;
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
